// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - refill state encoding and line field-width helpers
package icache_refill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } refill_state_e;

  localparam int LINE_WORDS_DEF = 4;
  localparam int INDEX_W_DEF    = 6;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w(input int line_words, input int index_w);
    return 32 - index_w - $clog2(line_words) - 2;
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - miss, memory-port and array-write bundle of the refill engine
interface icache_refill_if import icache_refill_pkg::*; #(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int INDEX_W    = INDEX_W_DEF
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int TAG_W = tag_w(LINE_WORDS, INDEX_W);

  logic               miss_valid;
  logic               miss_ready;
  logic [31:0]        miss_addr;
  logic               flush;
  logic               busy;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [31:0]        mem_req_addr;
  logic               mem_resp_valid;
  logic [31:0]        mem_resp_data;
  logic               mem_resp_err;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_index;
  logic [OFF_W-1:0]   arr_word;
  logic [31:0]        arr_wdata;
  logic               tag_we;
  logic [TAG_W-1:0]   tag_value;
  logic               refill_done;
  logic               refill_err;
  logic               crit_valid;
  logic [31:0]        crit_data;

  modport master (
    input  miss_valid, miss_addr, flush, mem_req_ready,
           mem_resp_valid, mem_resp_data, mem_resp_err,
    output miss_ready, busy, mem_req_valid, mem_req_addr, arr_we, arr_index,
           arr_word, arr_wdata, tag_we, tag_value, refill_done, refill_err,
           crit_valid, crit_data
  );

  modport slave (
    output miss_valid, miss_addr, flush, mem_req_ready,
           mem_resp_valid, mem_resp_data, mem_resp_err,
    input  miss_ready, busy, mem_req_valid, mem_req_addr, arr_we, arr_index,
           arr_word, arr_wdata, tag_we, tag_value, refill_done, refill_err,
           crit_valid, crit_data
  );
endinterface

// File: rtl/icache_refill_wrap_ctr.sv
// rtl/icache_refill_wrap_ctr.sv - word counter with wrapping (start+cnt) slot index
module icache_refill_wrap_ctr #(
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OFF_W-1:0] start_i,
  input  logic             inc_i,
  output logic [OFF_W-1:0] widx_o,
  output logic             first_o,
  output logic             last_o
);
  logic [OFF_W-1:0] cnt_q;
  logic [OFF_W-1:0] start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      start_q <= '0;
    end else if (load_i) begin
      cnt_q   <= '0;
      start_q <= start_i;
    end else if (inc_i) begin
      cnt_q   <= cnt_q + OFF_W'(1);
    end
  end

  // LINE_WORDS is a power of two, so the OFF_W-bit add wraps modulo the line
  assign widx_o  = start_q + cnt_q;
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == OFF_W'(LINE_WORDS - 1));
endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache line-refill engine; ICACHE_REFILL_CWF_EN selects critical-word-first
module icache_refill import icache_refill_pkg::*; #(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int INDEX_W    = INDEX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.master bus
);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int LINE_W = 32 - OFF_W - 2;

  refill_state_e     state_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;
  logic [OFF_W-1:0]  start_d;
  logic [OFF_W-1:0]  widx;
  logic              ctr_load, ctr_first, ctr_last;
  logic              req_hs, resp_ok;
  logic              unused_bits;

  assign req_hs   = (state_q == ST_ADDR) && bus.mem_req_ready;
  assign resp_ok  = (state_q == ST_DATA) && bus.mem_resp_valid && !bus.mem_resp_err && !bus.flush;
  assign ctr_load = (state_q == ST_IDLE) && bus.miss_valid;

`ifdef ICACHE_REFILL_CWF_EN
  assign start_d         = bus.miss_addr[OFF_W+1:2];
  assign bus.crit_valid  = resp_ok && ctr_first;
  assign bus.crit_data   = (resp_ok && ctr_first) ? bus.mem_resp_data : '0;
  assign unused_bits     = ^bus.miss_addr[1:0];
`else
  assign start_d         = '0;
  assign bus.crit_valid  = 1'b0;
  assign bus.crit_data   = '0;
  assign unused_bits     = ^{bus.miss_addr[OFF_W+1:0], ctr_first};
`endif

  icache_refill_wrap_ctr #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ctr_load),
    .start_i (start_d),
    .inc_i   (resp_ok),
    .widx_o  (widx),
    .first_o (ctr_first),
    .last_o  (ctr_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.miss_valid) begin
          line_q  <= bus.miss_addr[31:OFF_W+2];
          state_q <= ST_ADDR;
        end
        // A request already handed to memory must have its response drained
        ST_ADDR: begin
          if (bus.flush)   state_q <= req_hs ? ST_DRAIN : ST_IDLE;
          else if (req_hs) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (bus.mem_resp_valid) begin
            if (bus.flush) begin
              state_q <= ST_IDLE;
            end else if (bus.mem_resp_err) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ctr_last ? ST_DONE : ST_ADDR;
            end
          end else if (bus.flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (bus.mem_resp_valid) state_q <= ST_IDLE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.miss_ready    = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.mem_req_valid = (state_q == ST_ADDR);
  assign bus.mem_req_addr  = (state_q == ST_ADDR) ? {line_q, widx, 2'b00} : '0;
  assign bus.arr_we        = resp_ok;
  assign bus.arr_index     = line_q[INDEX_W-1:0];
  assign bus.arr_word      = widx;
  assign bus.arr_wdata     = resp_ok ? bus.mem_resp_data : '0;
  assign bus.tag_we        = (state_q == ST_DONE);
  assign bus.tag_value     = line_q[LINE_W-1:INDEX_W];
  assign bus.refill_done   = (state_q == ST_DONE);
  assign bus.refill_err    = err_q;
endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed bench for the icache refill engine
module tb_icache_refill;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic rst;
  icache_refill_if #(.LINE_WORDS(4), .INDEX_W(6)) bus ();

  icache_refill #(.LINE_WORDS(4), .INDEX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  int resp_delay = 0, req_wait = 0, err_at = 0, resp_count = 0;
  int accept_cyc, idle_cyc, tag_cyc, crit_cyc, resp_cyc;
  int tag_cnt, done_cnt, err_cnt, crit_cnt, viol;
  logic [21:0] tag_val;
  logic [31:0] crit_val;
  logic [1:0]  arr_word_q[$];
  logic [31:0] arr_data_q[$];
  logic [5:0]  arr_idx_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory: ready after req_wait stalled cycles, response resp_delay cycles after handshake
  initial begin : mem_model
    bit hs, pend;
    int dly, wait_cnt;
    logic [31:0] hs_addr, paddr;
    pend = 0; wait_cnt = 0; dly = 0; paddr = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_err = 0; bus.mem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready;
      hs_addr = bus.mem_req_addr;
      @(posedge clk); #1;
      bus.mem_resp_valid = 0; bus.mem_resp_err = 0; bus.mem_resp_data = '0;
      if (hs) begin pend = 1; dly = resp_delay; paddr = hs_addr; end
      if (pend) begin
        if (dly == 0) begin
          pend = 0; resp_count++;
          bus.mem_resp_valid = 1; bus.mem_resp_data = paddr ^ DATA_KEY;
          bus.mem_resp_err = (resp_count == err_at);
        end else dly--;
      end
      if (bus.mem_req_valid && wait_cnt >= req_wait) bus.mem_req_ready = 1;
      else begin
        bus.mem_req_ready = 0;
        wait_cnt = bus.mem_req_valid ? wait_cnt + 1 : 0;
      end
    end
  end

  initial begin : monitor
    bit stall_prev;
    logic [31:0] prev_addr;
    stall_prev = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.arr_we) begin
        arr_word_q.push_back(bus.arr_word);
        arr_data_q.push_back(bus.arr_wdata);
        arr_idx_q.push_back(bus.arr_index);
      end
      if (bus.arr_we && !bus.mem_resp_valid) viol++;
      if (stall_prev && (!bus.mem_req_valid || bus.mem_req_addr != prev_addr)) viol++;
      stall_prev = bus.mem_req_valid && !bus.mem_req_ready;
      prev_addr = bus.mem_req_addr;
      if (bus.tag_we) begin tag_cnt++; tag_val = bus.tag_value; tag_cyc = cyc; end
      if (bus.refill_done) done_cnt++;
      if (bus.refill_err) err_cnt++;
      if (bus.crit_valid) begin crit_cnt++; crit_val = bus.crit_data; crit_cyc = cyc; end
      if (bus.mem_resp_valid) resp_cyc = cyc;
    end
  end

  task automatic clear_log();
    arr_word_q.delete(); arr_data_q.delete(); arr_idx_q.delete();
    tag_cnt = 0; done_cnt = 0; err_cnt = 0; crit_cnt = 0; viol = 0;
    tag_val = '0; crit_val = '0; tag_cyc = 0; crit_cyc = 0; resp_count = 0;
  endtask

  task automatic issue_miss(input logic [31:0] a);
    @(posedge clk); #1;
    bus.miss_valid = 1; bus.miss_addr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.miss_ready) begin accept_cyc = cyc; break; end
    end
    @(posedge clk); #1;
    bus.miss_valid = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1; idle_cyc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (bus.miss_ready !== 1'b1) begin fails++; $display("FAIL rst_miss_ready: got %0b want 1", bus.miss_ready); end
    vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    vectors++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %0b want 0", bus.mem_req_valid); end
    vectors++; if (bus.arr_we !== 1'b0) begin fails++; $display("FAIL rst_arr_we: got %0b want 0", bus.arr_we); end
    vectors++; if (bus.tag_we !== 1'b0) begin fails++; $display("FAIL rst_tag_we: got %0b want 0", bus.tag_we); end
    vectors++; if (bus.refill_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", bus.refill_done); end
    vectors++; if (bus.refill_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", bus.refill_err); end
    vectors++; if (bus.crit_valid !== 1'b0) begin fails++; $display("FAIL rst_crit: got %0b want 0", bus.crit_valid); end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_basic();
    bit ok;
    int st, w;
    logic [31:0] exp;
    clear_log(); resp_delay = 0; req_wait = 0; err_at = 0;
    issue_miss(32'h0000_1008);
    wait_idle(ok);
    st = CWF ? 2 : 0;
    vectors++; if (!ok) begin fails++; $display("FAIL basic_idle: timeout, want return to idle"); end
    vectors++; if (arr_word_q.size() !== 4) begin fails++; $display("FAIL basic_nwrites: got %0d want 4", arr_word_q.size()); end
    for (int k = 0; k < 4 && k < arr_word_q.size(); k++) begin
      w = (st + k) % 4;
      exp = (32'h0000_1000 + 32'(4 * w)) ^ DATA_KEY;
      vectors++; if (arr_word_q[k] !== 2'(w)) begin fails++; $display("FAIL basic_word%0d: got %0d want %0d", k, arr_word_q[k], w); end
      vectors++; if (arr_data_q[k] !== exp) begin fails++; $display("FAIL basic_data%0d: got %h want %h", k, arr_data_q[k], exp); end
      vectors++; if (arr_idx_q[k] !== 6'd0) begin fails++; $display("FAIL basic_index%0d: got %0d want 0", k, arr_idx_q[k]); end
    end
    vectors++; if (tag_cnt !== 1) begin fails++; $display("FAIL basic_tag_cnt: got %0d want 1", tag_cnt); end
    vectors++; if (tag_val !== 22'h4) begin fails++; $display("FAIL basic_tag_val: got %h want 4", tag_val); end
    vectors++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    vectors++; if (tag_cyc - accept_cyc !== 9) begin fails++; $display("FAIL basic_latency: got %0d want 9", tag_cyc - accept_cyc); end
    vectors++; if (err_cnt !== 0) begin fails++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
    vectors++; if (crit_cnt !== (CWF ? 1 : 0)) begin fails++; $display("FAIL basic_crit_cnt: got %0d want %0d", crit_cnt, CWF ? 1 : 0); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] exp;
    clear_log(); resp_delay = 0; req_wait = 3;
    issue_miss(32'h0000_2340);
    wait_idle(ok);
    vectors++; if (!ok) begin fails++; $display("FAIL stall_idle: timeout, want return to idle"); end
    vectors++; if (arr_word_q.size() !== 4) begin fails++; $display("FAIL stall_nwrites: got %0d want 4", arr_word_q.size()); end
    for (int k = 0; k < 4 && k < arr_word_q.size(); k++) begin
      exp = (32'h0000_2340 + 32'(4 * k)) ^ DATA_KEY;
      vectors++; if (arr_data_q[k] !== exp) begin fails++; $display("FAIL stall_data%0d: got %h want %h", k, arr_data_q[k], exp); end
    end
    vectors++; if (arr_idx_q.size() > 0 && arr_idx_q[0] !== 6'h34) begin fails++; $display("FAIL stall_index: got %h want 34", arr_idx_q[0]); end
    vectors++; if (viol !== 0) begin fails++; $display("FAIL stall_hold: got %0d violations want 0", viol); end
    vectors++; if (tag_val !== 22'h8) begin fails++; $display("FAIL stall_tag_val: got %h want 8", tag_val); end
    vectors++; if (tag_cyc - accept_cyc !== 21) begin fails++; $display("FAIL stall_latency: got %0d want 21", tag_cyc - accept_cyc); end
    req_wait = 0;
  endtask

  task automatic test_flush();
    bit ok, found;
    clear_log(); resp_delay = 0; req_wait = 3;
    issue_miss(32'h0000_3000);
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_addr_busy: got %0b want 0", bus.busy); end
    vectors++; if (arr_word_q.size() !== 0) begin fails++; $display("FAIL flush_addr_writes: got %0d want 0", arr_word_q.size()); end

    clear_log(); resp_delay = 2; req_wait = 0;
    issue_miss(32'h0000_3000);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.mem_req_valid && !bus.mem_resp_valid && arr_word_q.size() == 1) begin found = 1; break; end
    end
    vectors++; if (!found) begin fails++; $display("FAIL flush_find_data1: timeout, want DATA for word 1"); end
    @(posedge clk); #1;
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    wait_idle(ok);
    vectors++; if (!ok) begin fails++; $display("FAIL flush_idle: timeout, want return to idle"); end
    vectors++; if (arr_word_q.size() !== 1) begin fails++; $display("FAIL flush_writes: got %0d want 1", arr_word_q.size()); end
    vectors++; if (tag_cnt !== 0) begin fails++; $display("FAIL flush_tag: got %0d want 0", tag_cnt); end
    vectors++; if (done_cnt !== 0) begin fails++; $display("FAIL flush_done: got %0d want 0", done_cnt); end
    vectors++; if (idle_cyc !== resp_cyc + 1) begin fails++; $display("FAIL flush_busy_drop: got %0d want %0d", idle_cyc, resp_cyc + 1); end

    clear_log(); resp_delay = 0;
    issue_miss(32'h0000_3010);
    wait_idle(ok);
    vectors++; if (arr_word_q.size() !== 4) begin fails++; $display("FAIL flush_next_writes: got %0d want 4", arr_word_q.size()); end
    vectors++; if (tag_cnt !== 1) begin fails++; $display("FAIL flush_next_tag: got %0d want 1", tag_cnt); end
    vectors++; if (arr_idx_q.size() > 0 && arr_idx_q[0] !== 6'd1) begin fails++; $display("FAIL flush_next_index: got %0d want 1", arr_idx_q[0]); end
  endtask

  task automatic test_bus_err();
    bit ok;
    clear_log(); resp_delay = 0; req_wait = 0; err_at = 3;
    issue_miss(32'h0000_4000);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    vectors++; if (arr_word_q.size() !== 2) begin fails++; $display("FAIL err_writes: got %0d want 2", arr_word_q.size()); end
    vectors++; if (arr_word_q.size() > 1 && arr_word_q[1] !== 2'd1) begin fails++; $display("FAIL err_word1: got %0d want 1", arr_word_q[1]); end
    vectors++; if (err_cnt !== 1) begin fails++; $display("FAIL err_pulse: got %0d cycles want 1", err_cnt); end
    vectors++; if (tag_cnt !== 0) begin fails++; $display("FAIL err_tag: got %0d want 0", tag_cnt); end
    vectors++; if (done_cnt !== 0) begin fails++; $display("FAIL err_done: got %0d want 0", done_cnt); end
    err_at = 0;
  endtask

  task automatic test_reset_mid();
    bit found;
    int rel;
    clear_log(); resp_delay = 4; req_wait = 0;
    issue_miss(32'h0000_5000);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.mem_req_valid) begin found = 1; break; end
    end
    vectors++; if (!found) begin fails++; $display("FAIL rmid_find_data: timeout, want DATA"); end
    #2 rst = 0;
    #1;
    vectors++; if (bus.miss_ready !== 1'b1) begin fails++; $display("FAIL rmid_miss_ready: got %0b want 1", bus.miss_ready); end
    vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %0b want 0", bus.busy); end
    vectors++; if (bus.mem_req_addr !== 32'h0) begin fails++; $display("FAIL rmid_req_addr: got %h want 0", bus.mem_req_addr); end
    vectors++; if (bus.tag_value !== 22'h0) begin fails++; $display("FAIL rmid_tag_value: got %h want 0", bus.tag_value); end
    @(posedge clk); #1;
    rst = 1; rel = cyc;
    repeat (8) @(negedge clk);
    vectors++; if (resp_cyc <= rel) begin fails++; $display("FAIL rmid_late_resp: got cycle %0d want > %0d", resp_cyc, rel); end
    vectors++; if (arr_word_q.size() !== 0) begin fails++; $display("FAIL rmid_writes: got %0d want 0", arr_word_q.size()); end
    vectors++; if (tag_cnt !== 0) begin fails++; $display("FAIL rmid_tag: got %0d want 0", tag_cnt); end
    resp_delay = 0;
  endtask

  task automatic test_cwf();
    bit ok;
    logic [31:0] exp_crit;
    clear_log(); resp_delay = 0; req_wait = 0;
    issue_miss(32'h0000_600C);
    wait_idle(ok);
    exp_crit = CWF ? (32'h0000_600C ^ DATA_KEY) : 32'h0;
    vectors++; if (arr_word_q.size() > 0 && arr_word_q[0] !== (CWF ? 2'd3 : 2'd0)) begin fails++; $display("FAIL cwf_first_word: got %0d want %0d", arr_word_q[0], CWF ? 3 : 0); end
    vectors++; if (crit_cnt !== (CWF ? 1 : 0)) begin fails++; $display("FAIL cwf_crit_cnt: got %0d want %0d", crit_cnt, CWF ? 1 : 0); end
    vectors++; if (crit_val !== exp_crit) begin fails++; $display("FAIL cwf_crit_data: got %h want %h", crit_val, exp_crit); end
    vectors++; if (crit_cyc !== (CWF ? accept_cyc + 2 : 0)) begin fails++; $display("FAIL cwf_crit_cycle: got %0d want %0d", crit_cyc, CWF ? accept_cyc + 2 : 0); end
    vectors++; if (tag_cnt !== 1) begin fails++; $display("FAIL cwf_tag: got %0d want 1", tag_cnt); end
  endtask

  initial begin
    rst = 0;
    bus.miss_valid = 0; bus.miss_addr = '0; bus.flush = 0;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_bus_err();
    test_reset_mid();
    test_cwf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
